imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader: writes the instruction memory that the fetch path reads.
- Takes a byte stream over a valid/ready handshake from a host link, such as a UART receiver.
- Packs each 4 bytes into one 32-bit instruction, MSB first, and drives the memory write port at consecutive word addresses from 0.
- Holds the CPU in reset while loading; releases it when the load completes.

Parameters:
- DEPTH, 40, instruction memory depth in words.
- ADDR_W, 6, write-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Ignored unless idle or done.
- len_words  in  ADDR_W+1  number of words to load; latched on start.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  instruction word.
- busy  out  1  load in progress.
- done  out  1  load complete; sticky until the next start or reset.
- cpu_hold  out  1  reset request to the CPU core.
- csum_err  out  1  checksum mismatch; sticky (optional feature only).

Behaviour:
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, csum_err=0. cpu_hold=1 from reset until the first load completes.
- States: IDLE, COLLECT, WRITE, CHECK (optional feature only), DONE.
- IDLE:
  - byte_ready=0.
  - On start: latch len = min(len_words, DEPTH); clear the word counter, byte counter and done; assert cpu_hold.
  - If len==0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1, busy=1.
  - A byte transfers when byte_valid and byte_ready are both high.
  - Each transfer shifts the byte into the assembly register: asm <= {asm[23:0], byte_data}.
  - On the 4th byte, go to WRITE.
- WRITE, exactly one cycle:
  - wr_en=1, wr_addr=word counter, wr_data=assembled word; byte_ready=0.
  - Write latency: the 4th byte's handshake cycle, then wr_en in the next cycle.
  - Then increment the word counter. If the counter reaches len, go to DONE (or CHECK with the feature); otherwise return to COLLECT.
- DONE:
  - done=1, busy=0, cpu_hold=0, byte_ready=0.
  - start re-enters the load sequence from the start-handling step of IDLE.
- Address rules:
  - wr_addr never reaches DEPTH; a len_words > DEPTH is clamped.
  - No wrap-around within a load.
- start while busy is ignored.
- byte_valid while not ready is not consumed; the host holds the byte.
- Reset mid-load: abandons the partial word, returns to IDLE, done=0, cpu_hold=1. No wr_en is issued in the reset cycle or after it.
- Memory contents already written are not cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2**32) accumulates every written word; cleared on start.
  - After the last word, CHECK collects 4 further bytes (MSB first) as the expected sum.
  - csum_err <= (expected != sum). The block then enters DONE.
  - cpu_hold stays 1 if csum_err=1.
- Not defined:
  - No CHECK state.
  - csum_err tied to 0.
  - The transition is WRITE directly to DONE.

Decomposition:
- Shared package mips_pkg:
  - constants IMEM_DEPTH=40 and IMEM_ADDR_W=6;
  - loader state enum (IDLE, COLLECT, WRITE, CHECK, DONE).
- One natural sub-module: imem_byte_packer. Handles the byte counter plus shift register, outputs word_valid, and is cleared by reset or start.
- The FSM and address counter stay in imem_loader.

Test Plan:
1. Back-to-back load:
   - Stimulus: reset, then start with len_words=2; bytes 8C,01,00,04,00,22,18,20 with byte_valid held high.
   - Response: wr_en at addr 0 with 0x8C010004, then at addr 1 with 0x00221820; done=1; cpu_hold 1->0.
2. Stalling host:
   - Stimulus: len_words=1; insert 3 idle cycles between bytes.
   - Response: exactly one wr_en, data correct, no byte lost or duplicated.
3. Clamp and zero length:
   - Stimulus: len_words=45.
   - Response: 40 writes, addr 0..39, then done.
   - Stimulus: len_words=0.
   - Response: done the next cycle, no wr_en.
4. Reset mid-load:
   - Stimulus: reset after 6 bytes of a 3-word load.
   - Response: only word 0 written; no further wr_en; done=0; cpu_hold=1; byte_ready=0.
5. Start while busy:
   - Stimulus: pulse start during COLLECT.
   - Response: ignored; the current load completes unchanged.
6. Checksum (IMEM_LOADER_CHECKSUM_EN):
   - Stimulus: words 0x00000001 and 0x00000002, then expected sum 00,00,00,03.
   - Response: csum_err=0, cpu_hold=0.
   - Stimulus: repeat with expected sum 04.
   - Response: csum_err=1, cpu_hold=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory side.
//   IMEM_DEPTH  : instruction memory depth in words
//   IMEM_ADDR_W : instruction memory word-address width
//   loader_state_t : program loader FSM states
package mips_pkg;

  localparam int IMEM_DEPTH  = 40;
  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Byte-to-word packer for the program loader.
// Shifts accepted bytes in MSB first and flags the cycle in which the
// fourth byte of a word is accepted.
// Ports:
//   clk        : clock, posedge
//   reset      : synchronous active-high reset
//   clear      : synchronous clear (accepted start of a new load)
//   take       : a byte is transferred this cycle
//   byte_data  : the byte being transferred
//   word_valid : this transfer completes a word
//   word       : assembled word including the byte transferred this cycle
module imem_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_reg;
  // Only the three oldest bytes need storing; the fourth is taken straight
  // from byte_data in its handshake cycle so the word is ready one cycle early.
  logic [23:0] asm_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= 2'd0;
      asm_reg <= 24'd0;
    end else if (take) begin
      asm_reg <= {asm_reg[15:0], byte_data};
      cnt_reg <= cnt_reg + 2'd1;  // wraps to 0 after the fourth byte
    end
  end

  assign word_valid = take && (cnt_reg == 2'd3);
  assign word       = {asm_reg, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a byte stream from a host link over a
// valid/ready handshake, packs it MSB first into 32-bit instructions and
// writes them to consecutive instruction-memory words from address 0.
// The CPU is held in reset until a load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- after the last word a
// further 4-byte expected sum is received and compared with the mod-2^32
// sum of all written words.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start, len_words    : begin a load of len_words words (clamped to DEPTH)
//   byte_valid/ready/data : host byte stream
//   wr_en/addr/data     : instruction memory write port
//   busy, done          : load in progress / load complete (sticky)
//   cpu_hold            : reset request to the CPU core
//   csum_err            : checksum mismatch (sticky; 0 without the feature)
module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              csum_err
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   word_cnt_reg;
  logic [ADDR_W:0]   word_cnt_next;
  logic [ADDR_W:0]   len_clamped;
  logic              byte_ready_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              cpu_hold_reg;
  logic              start_accept;
  logic              take;
  logic              word_valid;
  logic [31:0]       word;

  // start only counts when no load is running
  assign start_accept  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign take          = byte_valid && byte_ready_reg;
  assign len_clamped   = (len_words > DEPTH_W) ? DEPTH_W : len_words;
  assign word_cnt_next = word_cnt_reg + 1'b1;

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_accept),
    .take       (take),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_reg;
  logic        csum_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      word_cnt_reg   <= '0;
      byte_ready_reg <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= 32'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      cpu_hold_reg   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_reg        <= 32'd0;
      csum_err_reg   <= 1'b0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            len_reg      <= len_clamped;
            word_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= 32'd0;
            csum_err_reg <= 1'b0;
`endif
            if (len_clamped == '0) begin
              state_reg      <= DONE;
              done_reg       <= 1'b1;
              cpu_hold_reg   <= 1'b0;
              busy_reg       <= 1'b0;
              byte_ready_reg <= 1'b0;
            end else begin
              state_reg      <= COLLECT;
              done_reg       <= 1'b0;
              cpu_hold_reg   <= 1'b1;
              busy_reg       <= 1'b1;
              byte_ready_reg <= 1'b1;
            end
          end
        end

        COLLECT: begin
          // Register the write port in the fourth byte's handshake cycle so
          // wr_en appears exactly one cycle later.
          if (word_valid) begin
            state_reg      <= WRITE;
            byte_ready_reg <= 1'b0;
            wr_en_reg      <= 1'b1;
            wr_addr_reg    <= word_cnt_reg[ADDR_W-1:0];
            wr_data_reg    <= word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg        <= sum_reg + word;
`endif
          end
        end

        WRITE: begin
          word_cnt_reg <= word_cnt_next;
          if (word_cnt_next == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_reg      <= CHECK;
            byte_ready_reg <= 1'b1;
`else
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            cpu_hold_reg   <= 1'b0;
`endif
          end else begin
            state_reg      <= COLLECT;
            byte_ready_reg <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (word_valid) begin
            state_reg      <= DONE;
            byte_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            csum_err_reg   <= (word != sum_reg);
            // a bad image keeps the core parked
            cpu_hold_reg   <= (word != sum_reg);
          end
        end
`endif

        default: begin
          state_reg      <= IDLE;
          byte_ready_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_reg;
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign cpu_hold   = cpu_hold_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign csum_err = csum_err_reg;
`else
  assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  len_words = 7'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic        csum_err;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .csum_err   (csum_err)
  );

  always #5 clk = ~clk;

  // write-port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      $display("write addr=%0d data=%08h", wr_addr, wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic start_load(input logic [6:0] len);
    len_words = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // presents one byte and returns just after its handshake edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    send_byte(v[31:24]);
    send_byte(v[23:16]);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_wr_en",      {31'd0, wr_en},      32'd0);
    check("rst_wr_addr",    {26'd0, wr_addr},    32'd0);
    check("rst_wr_data",    wr_data,             32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("rst_csum_err",   {31'd0, csum_err},   32'd0);

    // ---------------- 1: back-to-back two-word load
    start_load(7'd2);
    check("t1_busy",       {31'd0, busy},       32'd1);
    check("t1_ready",      {31'd0, byte_ready}, 32'd1);
    send_byte(8'h8C);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h04);
    // wr_en must be up in the cycle right after the fourth byte's handshake
    check("t1_lat_wr_en",  {31'd0, wr_en},      32'd1);
    check("t1_lat_addr",   {26'd0, wr_addr},    32'd0);
    check("t1_lat_data",   wr_data,             32'h8C010004);
    check("t1_lat_ready",  {31'd0, byte_ready}, 32'd0);
    check("t1_hold_mid",   {31'd0, cpu_hold},   32'd1);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h18);
    send_byte(8'h20);
    byte_valid = 1'b0;
    wait_done("t1_done");
    tick();
    check("t1_nwr",        log_data.size(),     32'd2);
    if (log_data.size() == 2) begin
      check("t1_addr0", {26'd0, log_addr[0]}, 32'd0);
      check("t1_data0", log_data[0],          32'h8C010004);
      check("t1_addr1", {26'd0, log_addr[1]}, 32'd1);
      check("t1_data1", log_data[1],          32'h00221820);
    end
    check("t1_hold_end",   {31'd0, cpu_hold},   32'd0);
    check("t1_busy_end",   {31'd0, busy},       32'd0);
    check("t1_ready_end",  {31'd0, byte_ready}, 32'd0);

    // ---------------- 2: stalling host, restarted from DONE
    log_addr.delete();
    log_data.delete();
    start_load(7'd1);
    check("t2_done_clr",   {31'd0, done},     32'd0);
    check("t2_hold",       {31'd0, cpu_hold}, 32'd1);
    begin
      logic [31:0] w;
      w = 32'h12345678;
      for (int i = 3; i >= 0; i--) begin
        send_byte(w[i*8 +: 8]);
        byte_valid = 1'b0;
        if (i != 0) begin
          tick();
          tick();
          tick();
        end
      end
    end
    wait_done("t2_done");
    tick();
    check("t2_nwr", log_data.size(), 32'd1);
    if (log_data.size() == 1) begin
      check("t2_addr", {26'd0, log_addr[0]}, 32'd0);
      check("t2_data", log_data[0],          32'h12345678);
    end

    // ---------------- 3a: length clamped to 40 words
    do_reset();
    start_load(7'd45);
    for (int i = 0; i < 40; i++) send_word(32'hC0000000 | i);
    byte_valid = 1'b0;
    wait_done("t3_done");
    tick();
    check("t3_nwr", log_data.size(), 32'd40);
    for (int i = 0; i < log_data.size(); i++) begin
      check($sformatf("t3_addr%0d", i), {26'd0, log_addr[i]}, i);
      check($sformatf("t3_data%0d", i), log_data[i], 32'hC0000000 | i);
    end
    check("t3_ready_end", {31'd0, byte_ready}, 32'd0);

    // ---------------- 3b: zero length
    do_reset();
    start_load(7'd0);
    check("t3z_done", {31'd0, done},     32'd1);
    check("t3z_busy", {31'd0, busy},     32'd0);
    check("t3z_hold", {31'd0, cpu_hold}, 32'd0);
    tick();
    tick();
    check("t3z_nwr", log_data.size(), 32'd0);

    // ---------------- 4: reset mid-load
    do_reset();
    start_load(7'd3);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    for (int i = 0; i < 6; i++) tick();
    check("t4_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    check("t4_nwr",   log_data.size(),     32'd1);
    if (log_data.size() == 1) check("t4_data0", log_data[0], 32'h11223344);
    check("t4_done",  {31'd0, done},       32'd0);
    check("t4_hold",  {31'd0, cpu_hold},   32'd1);
    check("t4_busy",  {31'd0, busy},       32'd0);

    // ---------------- 5: start while busy is ignored
    do_reset();
    start_load(7'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    byte_valid = 1'b0;
    start_load(7'd5);
    send_byte(8'hBE);
    send_byte(8'hEF);
    byte_valid = 1'b0;
    wait_done("t5_done");
    tick();
    check("t5_nwr", log_data.size(), 32'd1);
    if (log_data.size() == 1) check("t5_data", log_data[0], 32'hDEADBEEF);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---------------- 6: checksum good, then bad
    do_reset();
    start_load(7'd2);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    byte_valid = 1'b0;
    wait_done("t6_done_ok");
    check("t6_err_ok",  {31'd0, csum_err}, 32'd0);
    check("t6_hold_ok", {31'd0, cpu_hold}, 32'd0);
    start_load(7'd2);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000004);
    byte_valid = 1'b0;
    wait_done("t6_done_bad");
    check("t6_err_bad",  {31'd0, csum_err}, 32'd1);
    check("t6_hold_bad", {31'd0, cpu_hold}, 32'd1);
`else
    check("t6_err_off", {31'd0, csum_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
